// File: rtl/pq_pkg.sv
// Shared key/value item type for the priority-queue datapath blocks.
package pq_pkg;

  localparam int KEY_W = 8;
  localparam int VAL_W = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

endpackage : pq_pkg

// File: rtl/ra_pq_kvfifo.sv
// Small kv_t FIFO with occupancy count. Push into a full FIFO and pop from
// an empty one are ignored, so callers cannot corrupt pointers or count.
module ra_pq_kvfifo
  import pq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  kv_t                      din,
  input  logic                     pop,
  output kv_t                      head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  kv_t           mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage is not reset; only pointers/count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : ra_pq_kvfifo

// File: rtl/ra_pq_demux2.sv
// One-to-two demultiplexer for kv_t items with a FIFO buffer per output port.
// d_ready depends combinationally only on sel; a full port never bypasses.
module ra_pq_demux2
  import pq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  kv_t                    d,
  input  logic                   sel,
  input  logic                   d_valid,
  output logic                   d_ready,
  output kv_t                    y0,
  output logic                   y0_valid,
  input  logic                   y0_ready,
  output logic [$clog2(DEPTH):0] y0_count,
  output kv_t                    y1,
  output logic                   y1_valid,
  input  logic                   y1_ready,
  output logic [$clog2(DEPTH):0] y1_count
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;

  // Ready reflects room in whichever buffer sel currently addresses.
  always_comb begin
    d_ready = sel ? !full1 : !full0;
    push0   = d_valid && d_ready && !sel;
    push1   = d_valid && d_ready &&  sel;
  end

  assign y0_valid = !empty0;
  assign y1_valid = !empty1;

  ra_pq_kvfifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .din   (d),
    .pop   (y0_ready),
    .head  (y0),
    .full  (full0),
    .empty (empty0),
    .count (y0_count)
  );

  ra_pq_kvfifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .din   (d),
    .pop   (y1_ready),
    .head  (y1),
    .full  (full1),
    .empty (empty1),
    .count (y1_count)
  );

endmodule : ra_pq_demux2

// File: tb/tb_ra_pq_demux2.sv
// Directed scoreboard bench for ra_pq_demux2 (DEPTH=2).
module tb_ra_pq_demux2;
  import pq_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  kv_t           d;
  logic          sel;
  logic          d_valid;
  logic          d_ready;
  kv_t           y0, y1;
  logic          y0_valid, y1_valid;
  logic          y0_ready, y1_ready;
  logic [CW-1:0] y0_count, y1_count;

  int  checks;
  int  errors;
  kv_t q0[$];
  kv_t q1[$];

  ra_pq_demux2 #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .sel      (sel),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .y0       (y0),
    .y0_valid (y0_valid),
    .y0_ready (y0_ready),
    .y0_count (y0_count),
    .y1       (y1),
    .y1_valid (y1_valid),
    .y1_ready (y1_ready),
    .y1_count (y1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Compares each port's output against the scoreboard whenever a transfer out
  // is about to happen at the next rising edge.
  task automatic monitor();
    kv_t e;
    forever begin
      @(negedge clk);
      if (rst_n && y0_valid && y0_ready) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL y0_unexpected actual=%h expected=none t=%0t", y0, $time);
        end else begin
          e = q0.pop_front();
          if (y0 !== e) begin
            errors++;
            $display("FAIL y0_data actual=%h expected=%h t=%0t", y0, e, $time);
          end
        end
      end
      if (rst_n && y1_valid && y1_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL y1_unexpected actual=%h expected=none t=%0t", y1, $time);
        end else begin
          e = q1.pop_front();
          if (y1 !== e) begin
            errors++;
            $display("FAIL y1_data actual=%h expected=%h t=%0t", y1, e, $time);
          end
        end
      end
    end
  endtask

  // Applies inputs for one cycle and records an accepted item as expected
  // output of the selected port. Returns at the negedge, before the edge.
  task automatic drive(input logic dv, input logic s, input int key, input int val,
                       input logic r0, input logic r1);
    kv_t item;
    @(posedge clk);
    #1;
    item.key = KEY_W'(key);
    item.val = VAL_W'(val);
    d        = item;
    sel      = s;
    d_valid  = dv;
    y0_ready = r0;
    y1_ready = r1;
    @(negedge clk);
    if (d_valid && d_ready) begin
      if (sel) q1.push_back(item);
      else     q0.push_back(item);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    d        = '0;
    sel      = 1'b0;
    d_valid  = 1'b0;
    y0_ready = 1'b0;
    y1_ready = 1'b0;
    fork monitor(); join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_y0_valid", int'(y0_valid), 0);
    chk("rst_y1_valid", int'(y1_valid), 0);
    chk("rst_y0_count", int'(y0_count), 0);
    chk("rst_y1_count", int'(y1_count), 0);
    chk("rst_d_ready_sel0", int'(d_ready), 1);
    sel = 1'b1;
    #1;
    chk("rst_d_ready_sel1", int'(d_ready), 1);
    rst_n = 1'b1;

    // Single push to empty port 0, visible one cycle later
    drive(1'b1, 1'b0, 5, 'h12, 1'b0, 1'b0);
    chk("first_d_ready", int'(d_ready), 1);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("first_y0_valid", int'(y0_valid), 1);
    chk("first_y0_count", int'(y0_count), 1);
    chk("first_y1_valid", int'(y1_valid), 0);
    chk("first_y0_key", int'(y0.key), 5);
    chk("first_y0_val", int'(y0.val), 'h12);

    // Simultaneous push and pop on port 0 at count 1
    drive(1'b1, 1'b0, 7, 'h77, 1'b1, 1'b0);
    chk("pp_d_ready", int'(d_ready), 1);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("pp_y0_count", int'(y0_count), 1);
    chk("pp_y0_key", int'(y0.key), 7);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("pp_drained", int'(y0_count), 0);

    // Fill port 1, third push refused, then drain with no full bypass
    drive(1'b1, 1'b1, 1, 'h01, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 2, 'h02, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3, 'h03, 1'b0, 1'b0);
    chk("full1_d_ready", int'(d_ready), 0);
    chk("full1_count", int'(y1_count), 2);
    drive(1'b1, 1'b1, 3, 'h03, 1'b0, 1'b1);
    chk("full1_no_bypass", int'(d_ready), 0);
    drive(1'b1, 1'b1, 3, 'h03, 1'b0, 1'b1);
    chk("full1_room_ready", int'(d_ready), 1);
    chk("full1_count_pp", int'(y1_count), 1);
    drive(1'b0, 1'b1, 0, 0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("full1_drained", int'(y1_count), 0);

    // Alternating routing with both readies high
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'(i % 2), 10 + i, 'h80 + i, 1'b1, 1'b1);
      if (i > 0) begin
        chk("alt_prev_valid", int'((i % 2) ? y0_valid : y1_valid), 1);
        chk("alt_cur_count", int'((i % 2) ? y1_count : y0_count), 0);
      end
    end
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    chk("alt_last_y1_valid", int'(y1_valid), 1);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    chk("alt_y0_empty", int'(y0_count), 0);
    chk("alt_y1_empty", int'(y1_count), 0);

    // Port 0 full must not block traffic to port 1
    drive(1'b1, 1'b0, 20, 'h20, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 21, 'h21, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 22, 'h22, 1'b0, 1'b0);
    chk("iso_y0_full", int'(y0_count), 2);
    chk("iso_d_ready_sel1", int'(d_ready), 1);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("iso_y1_count", int'(y1_count), 1);
    chk("iso_y0_count", int'(y0_count), 2);
    chk("iso_y0_head", int'(y0.key), 20);
    drive(1'b1, 1'b0, 23, 'h23, 1'b1, 1'b0);
    chk("full0_no_bypass", int'(d_ready), 0);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("full0_after_pop", int'(y0_count), 1);

    // Both ports at 2 items, then asynchronous reset between edges
    drive(1'b1, 1'b0, 24, 'h24, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 25, 'h25, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("pre_rst_y0_count", int'(y0_count), 2);
    chk("pre_rst_y1_count", int'(y1_count), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_y0_valid", int'(y0_valid), 0);
    chk("arst_y1_valid", int'(y1_valid), 0);
    chk("arst_y0_count", int'(y0_count), 0);
    chk("arst_y1_count", int'(y1_count), 0);
    chk("arst_d_ready", int'(d_ready), 1);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1'b1, 1'b0, 9, 'h09, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    chk("post_rst_head", int'(y0.key), 9);
    chk("post_rst_count", int'(y0_count), 1);

    // Pops on empty ports are ignored
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    chk("empty_pop_y0", int'(y0_count), 0);
    chk("empty_pop_y1", int'(y1_count), 0);
    chk("empty_pop_valid0", int'(y0_valid), 0);

    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ra_pq_demux2

// File: doc/ra_pq_demux2.md
RA_PQ_DEMUX2 -- requirements
Module: ra_pq_demux2

Interface
REQ-001 Parameter DEPTH, default 2, per-output buffer depth in kv_t entries; SHALL be a power of two, >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 d  input  kv_t  incoming key-value item.
REQ-005 sel  input  1  destination select: 0 -> port y0, 1 -> port y1.
REQ-006 d_valid  input  1  d/sel valid this cycle.
REQ-007 d_ready  output  1  block accepts d this cycle.
REQ-008 y0, y1  output  kv_t  head item of port 0 / port 1 buffer.
REQ-009 y0_valid, y1_valid  output  1  head item present on port 0 / port 1.
REQ-010 y0_ready, y1_ready  input  1  downstream consumes head of port 0 / port 1.
REQ-011 y0_count, y1_count  output  $clog2(DEPTH)+1  current occupancy of each port buffer.

Function
REQ-012 Transfer in: occurs when d_valid && d_ready at a rising edge; d is written to the buffer selected by sel.
REQ-013 d_ready SHALL equal !full of the buffer selected by the current sel (combinational on sel; no other combinational input-to-output path).
REQ-014 Transfer out on port k: occurs when yk_valid && yk_ready at a rising edge; head entry removed.
REQ-015 Latency: an item accepted at edge N SHALL appear on yk, with yk_valid=1, after edge N if the buffer was empty (1 cycle); otherwise it follows FIFO order.
REQ-016 Per-port ordering SHALL be strict FIFO; items are never duplicated, dropped or reordered, and are never routed to the non-selected port.
REQ-017 yk_valid = (yk_count != 0); yk is the head entry and SHALL be held stable while yk_valid && !yk_ready.
REQ-018 Simultaneous push and pop on the same port SHALL be allowed at any occupancy with room (count 1..DEPTH-1, or 0 with pop not possible); count unchanged, FIFO order preserved.
REQ-019 Full port: count == DEPTH; d_ready=0 when sel addresses it, even if yk_ready=1 in the same cycle (no full-bypass).
REQ-020 Empty port: yk_ready ignored; count stays 0; no underflow.
REQ-021 Push on one port and pop on the other in the same cycle SHALL both complete independently.
REQ-022 Read/write pointers are log2(DEPTH) bits and SHALL wrap modulo DEPTH; count is updated +1/-1/0 per port per cycle.
REQ-023 yk is don't-care while yk_valid=0; it SHALL not be X-sensitive in downstream logic (driven from storage, never undriven).

Reset
REQ-024 While rst_n=0: pointers and counts = 0, y0_valid=y1_valid=0, y0_count=y1_count=0; d_ready reflects empty buffers (=1).
REQ-025 Reset asserted mid-operation SHALL discard all buffered items immediately (asynchronously); storage contents need not be cleared.
REQ-026 First transfer possible at the first rising edge after rst_n deasserts.

Structure
REQ-027 kv_t (key and value fields) and its field widths SHALL come from pq_pkg; no new package types are required.
REQ-028 One sub-module ra_pq_kvfifo (kv_t FIFO, parameter DEPTH, push/pop/full/empty/count) SHALL be instantiated twice; routing and ready logic live in ra_pq_demux2.

Verification
REQ-029 Reset, then d={key=5,val=0x12}, sel=0, d_valid=1 for one cycle -> next cycle y0={5,0x12}, y0_valid=1, y0_count=1, y1_valid=0.
REQ-030 DEPTH=2, y1_ready=0, push keys 1,2,3 to sel=1 back-to-back -> keys 1,2 accepted, d_ready=0 on third, y1_count=2; then y1_ready=1 -> y1 outputs 1 then 2, key 3 accepted once room exists and emerges third.
REQ-031 Port 0 holding 1 item, same cycle push key 7 to sel=0 and y0_ready=1 -> head pops, key 7 stored, y0_count stays 1, next y0 key=7.
REQ-032 Alternate sel 0/1 with keys 10..17 and both readies=1 -> y0 sees 10,12,14,16, y1 sees 11,13,15,17, each 1 cycle after acceptance.
REQ-033 Port 0 full, sel=1, d_valid=1 -> d_ready=1 and item enters port 1; port 0 unaffected.
REQ-034 Both ports holding 2 items, assert rst_n=0 between edges -> y0_valid=y1_valid=0 and counts=0 immediately; after release, pushed key 9 emerges first.
